instr_decode_stage: RTL and testbench
=====================================

// Module: instr_decode_stage
// PURPOSE
//  Decode stage feeding the 8-bit ALU and register file of the single-cycle CPU: accepts 32-bit
//  instructions (OP[31:24] DEST[23:16] SRC1[15:8] SRC2/IMM[7:0]) over valid/ready, emits
//  registered ALU select, register addresses, immediate and mux controls over valid/ready.
//  2-entry skid buffer gives full throughput with registered INSTR_READY; sits between fetch and ALU/regfile.
// PARAMETERS
//  REG_ADDR_W  3   register-address width (8 registers)
//  CNT_W       16  width of retired-instruction counter (INSTR_COUNT_EN only)
// PORTS
//  CLK          in   1   clock, rising edge
//  RESET_N      in   1   asynchronous active-low reset
//  INSTR_VALID  in   1   upstream instruction valid
//  INSTR        in   32  instruction word
//  INSTR_READY  out  1   stage can accept (registered)
//  DEC_VALID    out  1   decoded entry valid
//  DEC_READY    in   1   downstream accepts decoded entry
//  ALUOP        out  3   ALU SELECT: 000 fwd, 001 add, 010 and, 011 or
//  WRITEENABLE  out  1   regfile write enable for this entry
//  WRITEREG     out  3   destination register
//  READREG1     out  3   source register 1
//  READREG2     out  3   source register 2
//  IMMEDIATE    out  8   INSTR[7:0]
//  IMM_SEL      out  1   1: operand2 = IMMEDIATE; 0: regfile port 2
//  NEG_SEL      out  1   1: operand2 two's-complemented before ALU (sub)
//  ILLEGAL      out  1   entry carries an undecodable instruction
//  INSTR_COUNT  out  CNT_W  retired count (INSTR_COUNT_EN only)
// BEHAVIOUR
//  Reset (async, RESET_N=0): both entries empty, DEC_VALID=0, all decoded outputs 0, ILLEGAL=0,
//   INSTR_READY=1 on first edge after release is not required: INSTR_READY=1 while in reset too.
//  Reset mid-operation discards buffered entries; no partial handshake survives.
//  Accept = INSTR_VALID & INSTR_READY at rising CLK; emit = DEC_VALID & DEC_READY at rising CLK.
//  Latency: accepted instruction visible on outputs the next cycle when output reg empty or draining.
//  FSM on occupancy: EMPTY (DEC_VALID=0, RDY=1) -accept-> ONE; ONE (DEC_VALID=1, RDY=1):
//   accept&emit -> ONE (out reg reloaded), accept&!emit -> TWO (into skid), emit&!accept -> EMPTY;
//   TWO (RDY=0): emit -> ONE (skid moves to out reg, order preserved).
//  Outputs stable while DEC_VALID=1 & DEC_READY=0; INSTR ignored when INSTR_READY=0.
//  Decode (OP): 00 loadi: ALUOP=000 IMM_SEL=1 WE=1; 01 mov: 000 IMM=0 WE=1; 02 add: 001 WE=1;
//   03 sub: 001 NEG_SEL=1 WE=1; 04 and: 010 WE=1; 05 or: 011 WE=1. Unused fields still driven.
//  ILLEGAL=1, WE=0, ALUOP=000, IMM_SEL=0, NEG_SEL=0 when OP>05, or any register field has
//   nonzero bits above [REG_ADDR_W-1:0] (SRC2 field checked only for non-immediate ops).
//   Illegal entries still flow through handshake in order; stage never stalls on them.
// CONFIGURATION
//  INSTR_COUNT_EN defined: INSTR_COUNT increments by 1 per emit with ILLEGAL=0, wraps 2^CNT_W-1 -> 0,
//   reset 0. Undefined: port and counter absent, no logic generated.
// STRUCTURE
//  Package instr_decode_pkg: opcode localparams, ALUOP encodings, decoded-entry struct, occupancy enum.
//  Sub-module op_decode: combinational INSTR -> decoded-entry struct; instantiated once at input.
//  Top holds out reg, skid reg, occupancy FSM, optional counter.
// TESTING
//  Reset then INSTR=0x00030011 valid -> next cycle DEC_VALID=1 ALUOP=000 IMM_SEL=1 WRITEREG=3 IMMEDIATE=0x11.
//  sub 0x03020104 -> ALUOP=001 NEG_SEL=1 WE=1 READREG1=1 READREG2=4 WRITEREG=2.
//  DEC_READY=0, push 3 instrs -> 2 buffered, INSTR_READY=0 after second; release -> emitted in order.
//  OP=0x07 and dest 0x09 with reg op -> ILLEGAL=1 WE=0; next legal instr unaffected.
//  Back-to-back valid/ready held 1 for 100 cycles -> one emit per cycle, INSTR_COUNT=100 (with _EN).
//  RESET_N low while TWO full -> DEC_VALID=0, INSTR_READY=1 immediately; no stale emit after release.

Source files
------------

// File: rtl/instr_decode_pkg.sv
// Shared definitions for the instruction decode stage: opcodes, ALU select
// encodings, the decoded-entry record and the buffer occupancy states.
package instr_decode_pkg;

  localparam logic [7:0] OP_LOADI = 8'h00;
  localparam logic [7:0] OP_MOV   = 8'h01;
  localparam logic [7:0] OP_ADD   = 8'h02;
  localparam logic [7:0] OP_SUB   = 8'h03;
  localparam logic [7:0] OP_AND   = 8'h04;
  localparam logic [7:0] OP_OR    = 8'h05;

  localparam logic [2:0] ALU_FWD = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  // Register fields are kept at full 8-bit field width; the stage trims them
  // to the configured register-address width on output.
  typedef struct packed {
    logic [2:0] aluop;
    logic       we;
    logic [7:0] wreg;
    logic [7:0] rreg1;
    logic [7:0] rreg2;
    logic [7:0] imm;
    logic       imm_sel;
    logic       neg_sel;
    logic       illegal;
  } dec_entry_t;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_t;

endpackage

// File: rtl/instr_decode_stage_op_decode.sv
// Combinational opcode decoder: 32-bit instruction word -> decoded-entry record,
// including legality checks on opcode and register-field range.
module op_decode
  import instr_decode_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 3
) (
  input  logic [31:0] i_instr,
  output dec_entry_t  o_dec
);

  logic [7:0] w_op;
  logic [7:0] w_dest;
  logic [7:0] w_src1;
  logic [7:0] w_src2;
  logic       w_is_imm;
  logic       w_op_bad;
  logic       w_reg_bad;

  assign w_op   = i_instr[31:24];
  assign w_dest = i_instr[23:16];
  assign w_src1 = i_instr[15:8];
  assign w_src2 = i_instr[7:0];

  assign w_is_imm = (w_op == OP_LOADI);

  // SRC2 doubles as the immediate for loadi, so its upper bits are only
  // meaningful as a register address for the register-operand opcodes.
  assign w_reg_bad = ((w_dest >> REG_ADDR_W) != 8'd0) ||
                     ((w_src1 >> REG_ADDR_W) != 8'd0) ||
                     (!w_is_imm && ((w_src2 >> REG_ADDR_W) != 8'd0));

  always_comb begin
    o_dec         = '0;
    w_op_bad      = 1'b0;
    o_dec.wreg    = w_dest;
    o_dec.rreg1   = w_src1;
    o_dec.rreg2   = w_src2;
    o_dec.imm     = w_src2;

    case (w_op)
      OP_LOADI: begin
        o_dec.aluop   = ALU_FWD;
        o_dec.imm_sel = 1'b1;
        o_dec.we      = 1'b1;
      end
      OP_MOV: begin
        o_dec.aluop = ALU_FWD;
        o_dec.we    = 1'b1;
      end
      OP_ADD: begin
        o_dec.aluop = ALU_ADD;
        o_dec.we    = 1'b1;
      end
      OP_SUB: begin
        o_dec.aluop   = ALU_ADD;
        o_dec.neg_sel = 1'b1;
        o_dec.we      = 1'b1;
      end
      OP_AND: begin
        o_dec.aluop = ALU_AND;
        o_dec.we    = 1'b1;
      end
      OP_OR: begin
        o_dec.aluop = ALU_OR;
        o_dec.we    = 1'b1;
      end
      default: w_op_bad = 1'b1;
    endcase

    if (w_op_bad || w_reg_bad) begin
      o_dec.aluop   = ALU_FWD;
      o_dec.we      = 1'b0;
      o_dec.imm_sel = 1'b0;
      o_dec.neg_sel = 1'b0;
      o_dec.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/instr_decode_stage.sv
// Decode stage between fetch and ALU/regfile: 2-entry skid buffer with
// registered INSTR_READY. Optional retired counter under `INSTR_COUNT_EN.
module instr_decode_stage
  import instr_decode_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 3
`ifdef INSTR_COUNT_EN
  ,
  parameter int unsigned CNT_W = 16
`endif
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  input  logic                  INSTR_VALID,
  input  logic [31:0]           INSTR,
  output logic                  INSTR_READY,
  output logic                  DEC_VALID,
  input  logic                  DEC_READY,
  output logic [2:0]            ALUOP,
  output logic                  WRITEENABLE,
  output logic [REG_ADDR_W-1:0] WRITEREG,
  output logic [REG_ADDR_W-1:0] READREG1,
  output logic [REG_ADDR_W-1:0] READREG2,
  output logic [7:0]            IMMEDIATE,
  output logic                  IMM_SEL,
  output logic                  NEG_SEL,
  output logic                  ILLEGAL
`ifdef INSTR_COUNT_EN
  ,
  output logic [CNT_W-1:0]      INSTR_COUNT
`endif
);

  dec_entry_t w_dec;
  dec_entry_t r_out;
  dec_entry_t r_skid;
  occ_t       r_state;
  occ_t       w_state_nxt;
  logic       r_rdy;
  logic       w_accept;
  logic       w_emit;
  logic       w_load_out;
  logic       w_load_skid;
  logic       w_skid_to_out;

  op_decode #(
    .REG_ADDR_W(REG_ADDR_W)
  ) u_op_decode (
    .i_instr(INSTR),
    .o_dec  (w_dec)
  );

  assign w_accept = INSTR_VALID && r_rdy;
  assign w_emit   = (r_state != OCC_EMPTY) && DEC_READY;

  always_comb begin
    w_state_nxt   = r_state;
    w_load_out    = 1'b0;
    w_load_skid   = 1'b0;
    w_skid_to_out = 1'b0;
    case (r_state)
      OCC_EMPTY: begin
        if (w_accept) begin
          w_state_nxt = OCC_ONE;
          w_load_out  = 1'b1;
        end
      end
      OCC_ONE: begin
        if (w_accept && w_emit) begin
          w_load_out = 1'b1;
        end else if (w_accept) begin
          w_state_nxt = OCC_TWO;
          w_load_skid = 1'b1;
        end else if (w_emit) begin
          w_state_nxt = OCC_EMPTY;
        end
      end
      OCC_TWO: begin
        if (w_emit) begin
          w_state_nxt   = OCC_ONE;
          w_skid_to_out = 1'b1;
        end
      end
      default: w_state_nxt = OCC_EMPTY;
    endcase
  end

  // Ready is registered from the next occupancy so it never depends
  // combinationally on DEC_READY; it stays high throughout reset.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= OCC_EMPTY;
      r_rdy   <= 1'b1;
      r_out   <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rdy   <= (w_state_nxt != OCC_TWO);
      if (w_load_out) begin
        r_out <= w_dec;
      end else if (w_skid_to_out) begin
        r_out <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= w_dec;
      end
    end
  end

  assign INSTR_READY = r_rdy;
  assign DEC_VALID   = (r_state != OCC_EMPTY);
  assign ALUOP       = r_out.aluop;
  assign WRITEENABLE = r_out.we;
  assign WRITEREG    = r_out.wreg[REG_ADDR_W-1:0];
  assign READREG1    = r_out.rreg1[REG_ADDR_W-1:0];
  assign READREG2    = r_out.rreg2[REG_ADDR_W-1:0];
  assign IMMEDIATE   = r_out.imm;
  assign IMM_SEL     = r_out.imm_sel;
  assign NEG_SEL     = r_out.neg_sel;
  assign ILLEGAL     = r_out.illegal;

  // Upper register-field bits only feed the legality check at decode time.
  logic w_unused_hi;
  assign w_unused_hi = &{1'b0, r_out.wreg[7:REG_ADDR_W],
                         r_out.rreg1[7:REG_ADDR_W], r_out.rreg2[7:REG_ADDR_W]};

`ifdef INSTR_COUNT_EN
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_count <= '0;
    end else if (w_emit && !r_out.illegal) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign INSTR_COUNT = r_count;
`endif

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed self-checking bench for instr_decode_stage (INSTR_COUNT_EN optional).
module tb_instr_decode_stage;

  logic        CLK;
  logic        RESET_N;
  logic        INSTR_VALID;
  logic [31:0] INSTR;
  logic        INSTR_READY;
  logic        DEC_VALID;
  logic        DEC_READY;
  logic [2:0]  ALUOP;
  logic        WRITEENABLE;
  logic [2:0]  WRITEREG;
  logic [2:0]  READREG1;
  logic [2:0]  READREG2;
  logic [7:0]  IMMEDIATE;
  logic        IMM_SEL;
  logic        NEG_SEL;
  logic        ILLEGAL;
`ifdef INSTR_COUNT_EN
  logic [15:0] INSTR_COUNT;
`endif

  int checks = 0;
  int errors = 0;

  instr_decode_stage #(
    .REG_ADDR_W(3)
`ifdef INSTR_COUNT_EN
    ,
    .CNT_W(16)
`endif
  ) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .INSTR_VALID(INSTR_VALID),
    .INSTR      (INSTR),
    .INSTR_READY(INSTR_READY),
    .DEC_VALID  (DEC_VALID),
    .DEC_READY  (DEC_READY),
    .ALUOP      (ALUOP),
    .WRITEENABLE(WRITEENABLE),
    .WRITEREG   (WRITEREG),
    .READREG1   (READREG1),
    .READREG2   (READREG2),
    .IMMEDIATE  (IMMEDIATE),
    .IMM_SEL    (IMM_SEL),
    .NEG_SEL    (NEG_SEL),
    .ILLEGAL    (ILLEGAL)
`ifdef INSTR_COUNT_EN
    ,
    .INSTR_COUNT(INSTR_COUNT)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // {ALUOP, IMM_SEL, NEG_SEL, WE, ILLEGAL, WRITEREG, READREG1, READREG2, IMMEDIATE}
  logic [23:0] obs;
  assign obs = {ALUOP, IMM_SEL, NEG_SEL, WRITEENABLE, ILLEGAL,
                WRITEREG, READREG1, READREG2, IMMEDIATE};

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  alu;
    logic        imm;
    logic        neg;
    logic        we;
    logic        ill;
  } vec_t;

  vec_t tbl[12] = '{
    '{32'h00030011, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0},
    '{32'h01050600, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0},
    '{32'h02010203, 3'd1, 1'b0, 1'b0, 1'b1, 1'b0},
    '{32'h03020104, 3'd1, 1'b0, 1'b1, 1'b1, 1'b0},
    '{32'h04070605, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0},
    '{32'h05000102, 3'd3, 1'b0, 1'b0, 1'b1, 1'b0},
    '{32'h07010203, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1},
    '{32'h02090102, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1},
    '{32'h00020AFF, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1},
    '{32'h00040180, 3'd0, 1'b1, 1'b0, 1'b1, 1'b0},
    '{32'h01010209, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1},
    '{32'hFF070707, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1}
  };

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_reset();
    RESET_N     = 1'b0;
    INSTR_VALID = 1'b0;
    INSTR       = '0;
    DEC_READY   = 1'b0;
    repeat (2) tick();
    RESET_N = 1'b1;
  endtask

  task automatic test_reset();
    RESET_N     = 1'b0;
    INSTR_VALID = 1'b0;
    INSTR       = '0;
    DEC_READY   = 1'b0;
    repeat (2) tick();
    checks++;
    if ({DEC_VALID, INSTR_READY} !== 2'b01) begin
      errors++;
      $display("FAIL reset_handshake got valid=%0b ready=%0b exp valid=0 ready=1", DEC_VALID, INSTR_READY);
    end
    checks++;
    if (obs !== 24'h0) begin
      errors++;
      $display("FAIL reset_outputs got %h exp 000000", obs);
    end
`ifdef INSTR_COUNT_EN
    checks++;
    if (INSTR_COUNT !== 16'd0) begin
      errors++;
      $display("FAIL reset_count got %0d exp 0", INSTR_COUNT);
    end
`endif
    RESET_N = 1'b1;
    tick();
  endtask

  task automatic test_loadi();
    DEC_READY   = 1'b1;
    INSTR       = 32'h00030011;
    INSTR_VALID = 1'b1;
    tick();
    INSTR_VALID = 1'b0;
    checks++;
    if (DEC_VALID !== 1'b1) begin
      errors++;
      $display("FAIL loadi_valid got %0b exp 1", DEC_VALID);
    end
    // aluop 0, imm_sel 1, we 1, wreg 3, rr1 0, rr2 1, imm 0x11
    checks++;
    if (obs !== {3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd3, 3'd0, 3'd1, 8'h11}) begin
      errors++;
      $display("FAIL loadi_fields got %h exp %h", obs,
               {3'd0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd3, 3'd0, 3'd1, 8'h11});
    end
    tick();
    checks++;
    if (DEC_VALID !== 1'b0) begin
      errors++;
      $display("FAIL loadi_drain got %0b exp 0", DEC_VALID);
    end
  endtask

  task automatic test_sub();
    DEC_READY   = 1'b1;
    INSTR       = 32'h03020104;
    INSTR_VALID = 1'b1;
    tick();
    INSTR_VALID = 1'b0;
    checks++;
    if ({DEC_VALID, obs} !== {1'b1, 3'd1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd2, 3'd1, 3'd4, 8'h04}) begin
      errors++;
      $display("FAIL sub_fields got v=%0b %h exp v=1 %h", DEC_VALID, obs,
               {3'd1, 1'b0, 1'b1, 1'b1, 1'b0, 3'd2, 3'd1, 3'd4, 8'h04});
    end
    tick();
  endtask

  task automatic test_decode_table();
    logic [23:0] exp_obs;
    DEC_READY = 1'b1;
    for (int i = 0; i < 12; i++) begin
      INSTR       = tbl[i].instr;
      INSTR_VALID = 1'b1;
      tick();
      exp_obs = {tbl[i].alu, tbl[i].imm, tbl[i].neg, tbl[i].we, tbl[i].ill,
                 tbl[i].instr[18:16], tbl[i].instr[10:8], tbl[i].instr[2:0], tbl[i].instr[7:0]};
      checks++;
      if ({DEC_VALID, INSTR_READY, obs} !== {2'b11, exp_obs}) begin
        errors++;
        $display("FAIL decode_%0d instr=%h got v=%0b r=%0b %h exp v=1 r=1 %h",
                 i, tbl[i].instr, DEC_VALID, INSTR_READY, obs, exp_obs);
      end
    end
    INSTR_VALID = 1'b0;
    tick();
  endtask

  task automatic test_skid();
`ifdef INSTR_COUNT_EN
    logic [15:0] cnt0;
`endif
    DEC_READY   = 1'b1;
    INSTR_VALID = 1'b0;
    tick();
`ifdef INSTR_COUNT_EN
    cnt0 = INSTR_COUNT;
`endif
    DEC_READY   = 1'b0;
    INSTR       = 32'h02010203;
    INSTR_VALID = 1'b1;
    tick();
    checks++;
    if ({DEC_VALID, INSTR_READY, ALUOP, WRITEREG} !== {2'b11, 3'd1, 3'd1}) begin
      errors++;
      $display("FAIL skid_first got v=%0b r=%0b alu=%0d wr=%0d exp v=1 r=1 alu=1 wr=1",
               DEC_VALID, INSTR_READY, ALUOP, WRITEREG);
    end
    INSTR = 32'h04020304;
    tick();
    checks++;
    if ({DEC_VALID, INSTR_READY, ALUOP, WRITEREG} !== {2'b10, 3'd1, 3'd1}) begin
      errors++;
      $display("FAIL skid_full got v=%0b r=%0b alu=%0d wr=%0d exp v=1 r=0 alu=1 wr=1",
               DEC_VALID, INSTR_READY, ALUOP, WRITEREG);
    end
    INSTR = 32'h05030405;
    tick();
    checks++;
    if ({DEC_VALID, INSTR_READY, ALUOP, WRITEREG, READREG2} !== {2'b10, 3'd1, 3'd1, 3'd3}) begin
      errors++;
      $display("FAIL skid_hold got v=%0b r=%0b alu=%0d wr=%0d rr2=%0d exp v=1 r=0 alu=1 wr=1 rr2=3",
               DEC_VALID, INSTR_READY, ALUOP, WRITEREG, READREG2);
    end
    DEC_READY = 1'b1;
    tick();
    checks++;
    if ({DEC_VALID, INSTR_READY, ALUOP, WRITEREG} !== {2'b11, 3'd2, 3'd2}) begin
      errors++;
      $display("FAIL skid_second got v=%0b r=%0b alu=%0d wr=%0d exp v=1 r=1 alu=2 wr=2",
               DEC_VALID, INSTR_READY, ALUOP, WRITEREG);
    end
    tick();
    INSTR_VALID = 1'b0;
    checks++;
    if ({DEC_VALID, ALUOP, WRITEREG} !== {1'b1, 3'd3, 3'd3}) begin
      errors++;
      $display("FAIL skid_third got v=%0b alu=%0d wr=%0d exp v=1 alu=3 wr=3",
               DEC_VALID, ALUOP, WRITEREG);
    end
    tick();
    checks++;
    if (DEC_VALID !== 1'b0) begin
      errors++;
      $display("FAIL skid_drain got %0b exp 0", DEC_VALID);
    end
`ifdef INSTR_COUNT_EN
    checks++;
    if (INSTR_COUNT !== cnt0 + 16'd3) begin
      errors++;
      $display("FAIL skid_count got %0d exp %0d", INSTR_COUNT, cnt0 + 16'd3);
    end
`endif
  endtask

  task automatic test_reset_mid();
    DEC_READY   = 1'b0;
    INSTR       = 32'h02010203;
    INSTR_VALID = 1'b1;
    tick();
    INSTR = 32'h05020304;
    tick();
    INSTR_VALID = 1'b0;
    checks++;
    if ({DEC_VALID, INSTR_READY} !== 2'b10) begin
      errors++;
      $display("FAIL rstmid_full got v=%0b r=%0b exp v=1 r=0", DEC_VALID, INSTR_READY);
    end
    RESET_N = 1'b0;
    #1;
    checks++;
    if ({DEC_VALID, INSTR_READY} !== 2'b01) begin
      errors++;
      $display("FAIL rstmid_async got v=%0b r=%0b exp v=0 r=1", DEC_VALID, INSTR_READY);
    end
    tick();
    RESET_N   = 1'b1;
    DEC_READY = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (DEC_VALID !== 1'b0) begin
        errors++;
        $display("FAIL rstmid_stale_%0d got %0b exp 0", i, DEC_VALID);
      end
    end
  endtask

  task automatic test_back_to_back();
    int bad;
    logic [2:0] wr;
    apply_reset();
    bad       = 0;
    DEC_READY = 1'b1;
    for (int i = 0; i < 100; i++) begin
      wr          = 3'(i % 8);
      INSTR       = {8'h02, 5'd0, wr, 16'h0102};
      INSTR_VALID = 1'b1;
      tick();
      if (!(DEC_VALID === 1'b1 && INSTR_READY === 1'b1 && WRITEREG === wr && ALUOP === 3'd1))
        bad++;
    end
    INSTR_VALID = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL b2b_stream got %0d bad cycles exp 0", bad);
    end
    tick();
    checks++;
    if (DEC_VALID !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain got %0b exp 0", DEC_VALID);
    end
`ifdef INSTR_COUNT_EN
    checks++;
    if (INSTR_COUNT !== 16'd100) begin
      errors++;
      $display("FAIL b2b_count got %0d exp 100", INSTR_COUNT);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_loadi();
    test_sub();
    test_decode_table();
    test_skid();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
